// File: rtl/ae_sample_packer_if.sv
// ---------------------------------------------------------------------------
// ae_sample_packer_if
//
// Purpose: bundles the requantized sample stream coming from the AE rate
// adaptor and the word-write bus going to the AE sample buffer SRAM, so the
// packer sees both as a single port.
//
// Signals:
//   data_valid  sample strobe from the rate adaptor
//   data_quant  4-bit requantized sample {I[1:0], Q[1:0]}
//   mem_we      sample buffer write enable
//   mem_addr    sample buffer word address (ADDR_WIDTH bits)
//   mem_wdata   packed 32-bit word
//
// Modports:
//   master  the packer: consumes samples, drives the buffer write bus
//   slave   the surroundings: drive samples, observe the buffer write bus
// ---------------------------------------------------------------------------
interface ae_sample_packer_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  data_valid;
    logic [3:0]            data_quant;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        input  data_valid,
        input  data_quant,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output data_valid,
        output data_quant,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/ae_sample_packer.sv
// ---------------------------------------------------------------------------
// ae_sample_packer
//
// Purpose: packs 4-bit requantized samples from the AE rate adaptor, eight
// per 32-bit word (first sample in the LSBs), and writes the words to the AE
// sample buffer starting at word 0. Runs one capture session at a time:
// start (with an NCO init pulse to the rate adaptor), optional discard of
// pipeline-settling samples, fill to a programmed length, done or abort.
//
// Optional feature: define AE_PACKER_SKIP_EN to add the skip_count input and
// the SKIP state, which discards the first skip_count strobes after start.
//
// Ports:
//   clk           system clock
//   rst_b         asynchronous active-low reset
//   start_fill    pulse: begin / restart a session
//   abort_fill    pulse: terminate the session (wins over start_fill)
//   fill_length   words to capture, 0 means 2^ADDR_WIDTH (sampled on start)
//   skip_count    strobes to discard after start (AE_PACKER_SKIP_EN only)
//   init_nco      one-cycle pulse to the rate adaptor NCO/filter init
//   fill_busy     session in progress
//   fill_done     one-cycle pulse, coincident with the last word write
//   filled_words  words written in the current / last session
//   bus           sample stream in, sample buffer write bus out (master)
// ---------------------------------------------------------------------------
module ae_sample_packer #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start_fill,
    input  logic                  abort_fill,
    input  logic [ADDR_WIDTH-1:0] fill_length,
`ifdef AE_PACKER_SKIP_EN
    input  logic [3:0]            skip_count,
`endif
    output logic                  init_nco,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH:0]   filled_words,
    ae_sample_packer_if.master    bus
);

`ifdef AE_PACKER_SKIP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SKIP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FILL} state_t;
`endif

    state_t                state;
    logic [2:0]            sample_idx;
    logic [27:0]           pack_reg;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [ADDR_WIDTH:0]   length_q;
`ifdef AE_PACKER_SKIP_EN
    logic [3:0]            skip_left;
`endif

    logic accept;
    logic last_word;

    assign accept    = (state == ST_FILL) && bus.data_valid;
    // One bit wider than the word counter so a length of 2^ADDR_WIDTH fits.
    assign last_word = ({1'b0, word_cnt} == (length_q - 1'b1));

    // Session control, sample packing and the registered buffer write.
    // The packing register shifts samples in from the top, so after seven
    // samples the first one sits in the LSBs; the eighth sample is merged
    // straight into the write register, leaving the packing register free
    // to take the next word's first sample on the following cycle.
    // abort_fill and start_fill are applied last so they override the
    // session bookkeeping, while a write launched in the same cycle stands.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= ST_IDLE;
            sample_idx    <= '0;
            pack_reg      <= '0;
            word_cnt      <= '0;
            length_q      <= '0;
`ifdef AE_PACKER_SKIP_EN
            skip_left     <= '0;
`endif
            init_nco      <= 1'b0;
            fill_busy     <= 1'b0;
            fill_done     <= 1'b0;
            filled_words  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            init_nco   <= 1'b0;
            fill_done  <= 1'b0;
            bus.mem_we <= 1'b0;

            if (accept) begin
                pack_reg <= {bus.data_quant, pack_reg[27:4]};
                if (sample_idx == 3'd7) begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= word_cnt;
                    bus.mem_wdata <= {bus.data_quant, pack_reg};
                    word_cnt      <= word_cnt + 1'b1;
                    filled_words  <= filled_words + 1'b1;
                    sample_idx    <= '0;
                    if (last_word) begin
                        fill_done <= 1'b1;
                        fill_busy <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end else begin
                    sample_idx <= sample_idx + 1'b1;
                end
            end

`ifdef AE_PACKER_SKIP_EN
            if ((state == ST_SKIP) && bus.data_valid) begin
                skip_left <= skip_left - 1'b1;
                if (skip_left == 4'd1) begin
                    state <= ST_FILL;
                end
            end
`endif

            if (abort_fill) begin
                state     <= ST_IDLE;
                fill_busy <= 1'b0;
                fill_done <= 1'b0;
            end else if (start_fill) begin
                init_nco     <= 1'b1;
                fill_busy    <= 1'b1;
                fill_done    <= 1'b0;
                word_cnt     <= '0;
                sample_idx   <= '0;
                pack_reg     <= '0;
                filled_words <= '0;
                length_q     <= (fill_length == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}}
                                                    : {1'b0, fill_length};
`ifdef AE_PACKER_SKIP_EN
                skip_left    <= skip_count;
                state        <= (skip_count != 4'd0) ? ST_SKIP : ST_FILL;
`else
                state        <= ST_FILL;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ae_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_ae_sample_packer
//
// Purpose: self-checking bench for ae_sample_packer (ADDR_WIDTH = 4, so a
// full 16-word buffer fill is cheap). Directed session scenarios are fed
// with fixed or $urandom sample values; expected words are built from the
// list of samples sent using plain shift/OR arithmetic.
//
// Build with AE_PACKER_SKIP_EN defined to also exercise skip_count.
// ---------------------------------------------------------------------------
module tb_ae_sample_packer;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start_fill = 1'b0;
    logic          abort_fill = 1'b0;
    logic [AW-1:0] fill_length = '0;
`ifdef AE_PACKER_SKIP_EN
    logic [3:0]    skip_count = 4'd0;
`endif
    logic          init_nco;
    logic          fill_busy;
    logic          fill_done;
    logic [AW:0]   filled_words;

    ae_sample_packer_if #(.ADDR_WIDTH(AW)) bus ();

    ae_sample_packer #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .start_fill   (start_fill),
        .abort_fill   (abort_fill),
        .fill_length  (fill_length),
`ifdef AE_PACKER_SKIP_EN
        .skip_count   (skip_count),
`endif
        .init_nco     (init_nco),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .filled_words (filled_words),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            nco_cnt = 0;
    int            done_cnt = 0;
    bit            done_with_we = 1'b0;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [3:0]    sent_q[$];

    // Expected packed word: eight consecutive sent samples, first in LSBs.
    function automatic logic [31:0] pack_word(input int base);
        logic [31:0] word = '0;
        for (int k = 0; k < 8; k++) begin
            word = word | (32'(sent_q[base + k]) << (4 * k));
        end
        return word;
    endfunction

    // Advance one clock and log what the DUT shows just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
        if (fill_done === 1'b1) begin
            done_cnt++;
            done_with_we = bus.mem_we;
        end
        if (init_nco === 1'b1) begin
            nco_cnt++;
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        sent_q.delete();
        nco_cnt = 0;
        done_cnt = 0;
        done_with_we = 1'b0;
    endtask

    task automatic start_session(input logic [AW-1:0] len);
        fill_length = len;
        start_fill  = 1'b1;
        tick();
        start_fill  = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [3:0] value, input int gap);
        bus.data_valid = 1'b1;
        bus.data_quant = value;
        sent_q.push_back(value);
        tick();
        bus.data_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(4'($urandom), 0);
        end
    endtask

    task automatic compare_writes(input int n, input int skip);
        check_output("write_count", 64'(wr_data_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
            check_output("write_addr", 64'(wr_addr_q[i]), 64'(i));
            check_output("write_data", 64'(wr_data_q[i]), 64'(pack_word(skip + 8 * i)));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.data_valid = 1'b0;
        bus.data_quant = 4'h0;

        // Reset values
        repeat (2) tick();
        check_output("rst_init_nco", 64'(init_nco), 64'd0);
        check_output("rst_fill_busy", 64'(fill_busy), 64'd0);
        check_output("rst_fill_done", 64'(fill_done), 64'd0);
        check_output("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check_output("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check_output("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check_output("rst_filled_words", 64'(filled_words), 64'd0);
        rst_b = 1'b1;
        tick();

        // Two-word fill, samples 1..F,0 back to back
        clear_log();
        start_session(4'd2);
        check_output("t1_init_nco", 64'(init_nco), 64'd1);
        check_output("t1_busy_start", 64'(fill_busy), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            apply_stimulus(4'(i), 0);
        end
        check_output("t1_done_last", 64'(fill_done), 64'd1);
        check_output("t1_we_last", 64'(bus.mem_we), 64'd1);
        check_output("t1_busy_end", 64'(fill_busy), 64'd0);
        compare_writes(2, 0);
        if (wr_data_q.size() == 2) begin
            check_output("t1_word0", 64'(wr_data_q[0]), 64'h87654321);
            check_output("t1_word1", 64'(wr_data_q[1]), 64'h0FEDCBA9);
        end
        tick();
        check_output("t1_done_pulse", 64'(fill_done), 64'd0);
        check_output("t1_filled", 64'(filled_words), 64'd2);
        check_output("t1_done_cnt", 64'(done_cnt), 64'd1);
        check_output("t1_done_with_we", 64'(done_with_we), 64'd1);
        check_output("t1_nco_cnt", 64'(nco_cnt), 64'd1);

        // Sparse strobes, one-word fill, extra strobe after done
        clear_log();
        start_session(4'd1);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(4'hA, 2);
        end
        apply_stimulus(4'hA, 0);
        check_output("t2_we", 64'(bus.mem_we), 64'd1);
        check_output("t2_addr", 64'(bus.mem_addr), 64'd0);
        check_output("t2_data", 64'(bus.mem_wdata), 64'hAAAAAAAA);
        check_output("t2_done", 64'(fill_done), 64'd1);
        repeat (2) tick();
        apply_stimulus(4'hA, 1);
        check_output("t2_no_extra_write", 64'(wr_data_q.size()), 64'd1);
        check_output("t2_hold_data", 64'(bus.mem_wdata), 64'hAAAAAAAA);
        check_output("t2_hold_addr", 64'(bus.mem_addr), 64'd0);
        check_output("t2_filled", 64'(filled_words), 64'd1);

        // fill_length = 0: whole 16-word buffer, random samples
        clear_log();
        start_session(4'd0);
        send_random(128);
        check_output("t3_done_last", 64'(fill_done), 64'd1);
        check_output("t3_addr_last", 64'(bus.mem_addr), 64'd15);
        compare_writes(16, 0);
        send_random(8);
        tick();
        check_output("t3_no_wrap", 64'(wr_data_q.size()), 64'd16);
        check_output("t3_filled", 64'(filled_words), 64'd16);
        check_output("t3_busy", 64'(fill_busy), 64'd0);
        check_output("t3_done_cnt", 64'(done_cnt), 64'd1);

        // Abort after 13 samples, then restart
        clear_log();
        start_session(4'd4);
        send_random(13);
        abort_fill = 1'b1;
        tick();
        abort_fill = 1'b0;
        check_output("t4_busy", 64'(fill_busy), 64'd0);
        check_output("t4_filled", 64'(filled_words), 64'd1);
        send_random(3);
        tick();
        compare_writes(1, 0);
        check_output("t4_no_done", 64'(done_cnt), 64'd0);
        clear_log();
        start_session(4'd1);
        check_output("t4_restart_filled", 64'(filled_words), 64'd0);
        check_output("t4_restart_busy", 64'(fill_busy), 64'd1);
        send_random(8);
        compare_writes(1, 0);
        check_output("t4_restart_done", 64'(done_cnt), 64'd1);

        // Abort in the same cycle as the 8th sample: that write still lands
        clear_log();
        start_session(4'd4);
        send_random(7);
        abort_fill = 1'b1;
        send_random(1);
        abort_fill = 1'b0;
        check_output("t5_we", 64'(bus.mem_we), 64'd1);
        check_output("t5_busy", 64'(fill_busy), 64'd0);
        check_output("t5_done", 64'(fill_done), 64'd0);
        check_output("t5_filled", 64'(filled_words), 64'd1);
        compare_writes(1, 0);

        // start+abort together while idle, then strobes while idle
        clear_log();
        fill_length = 4'd2;
        start_fill  = 1'b1;
        abort_fill  = 1'b1;
        tick();
        start_fill  = 1'b0;
        abort_fill  = 1'b0;
        check_output("t6_init_nco", 64'(init_nco), 64'd0);
        check_output("t6_busy", 64'(fill_busy), 64'd0);
        send_random(8);
        tick();
        check_output("t6_nco_cnt", 64'(nco_cnt), 64'd0);
        check_output("t6_idle_writes", 64'(wr_data_q.size()), 64'd0);

        // Restart while busy with a write pending in the same cycle
        clear_log();
        start_session(4'd2);
        send_random(7);
        start_fill = 1'b1;
        send_random(1);
        start_fill = 1'b0;
        check_output("t7_pending_we", 64'(bus.mem_we), 64'd1);
        check_output("t7_pending_data", 64'(bus.mem_wdata), 64'(pack_word(0)));
        check_output("t7_init_nco", 64'(init_nco), 64'd1);
        check_output("t7_filled_cleared", 64'(filled_words), 64'd0);
        clear_log();
        send_random(16);
        compare_writes(2, 0);
        check_output("t7_filled", 64'(filled_words), 64'd2);

`ifdef AE_PACKER_SKIP_EN
        // Skip the first six strobes
        clear_log();
        skip_count = 4'd6;
        start_session(4'd1);
        skip_count = 4'd0;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(4'(i), 0);
        end
        compare_writes(1, 6);
        if (wr_data_q.size() == 1) begin
            check_output("t8_word", 64'(wr_data_q[0]), 64'hDCBA9876);
        end
        check_output("t8_done", 64'(done_cnt), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
